inv_sub_bytes_seq: RTL and testbench
====================================

# inv_sub_bytes_seq

Iterative inverse-SubBytes engine for the AES decryption datapath: takes a 128-bit state, replaces every byte with its FIPS-197 inverse S-box value, and returns the result. It processes one 32-bit column per clock through a single 32-bit inverse S-box slice of four byte lookups, mirroring the encryption-side 32-bit S-box. It sits between InvShiftRows and AddRoundKey in the decryption round loop, with valid/ready handshakes on both sides.

## Interface

- No parameters. Widths are fixed by AES: 128-bit state, 32-bit column, 8-bit byte.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents in_state
- in_ready  out  1  block can accept; high only in IDLE
- in_state  in  128  state to transform; column 0 = [127:96], column 3 = [31:0]
- out_valid  out  1  out_state holds a finished result
- out_ready  in  1  downstream accepts out_state
- out_state  out  128  inverse-substituted state
- busy  out  1  high in BUSY or DONE

## Operation

- Internal storage: 128-bit state register (drives out_state), 2-bit column counter cnt, FSM {IDLE, BUSY, DONE}.
- Lookup slice: one combinational 32-bit inverse S-box of four byte tables. Its input is column cnt of the state register. Byte order within the column is preserved: bits [31:24] in give bits [31:24] out.
- IDLE: in_ready=1. On in_valid, load in_state into the state register, set cnt=0, go to BUSY. Without in_valid, hold.
- BUSY: on each edge, write the slice output back over column cnt, then increment cnt. The write at cnt=3 moves the FSM to DONE and wraps cnt to 0. in_valid is ignored and in_state is not sampled.
- DONE: out_valid=1 and out_state is stable. On out_ready, go to IDLE. Otherwise hold indefinitely with the data unchanged.
- Columns are transformed in the fixed order 0,1,2,3. Each byte is transformed exactly once; there is no double substitution.
- There is no accept-in-DONE bypass. in_ready never depends combinationally on out_ready.
- Reset (rst=1 at an edge), from any state including mid-BUSY or DONE with out_ready low: FSM=IDLE, cnt=0, state register=0. Any partial result is discarded.

## Timing

- Reset values: in_ready=1, out_valid=0, busy=0, out_state=128'h0.
- Accept edge E0 is the edge where in_valid is high in IDLE. Columns 0–3 are written on edges E1–E4. out_valid rises after E4.
- Latency: 4 cycles from accept edge to out_valid.
- Minimum block period: 6 cycles (accept, 4 busy, 1 DONE with out_ready already high). The next accept is possible at the edge after the output handshake edge, because in_ready rises once IDLE is re-entered.
- All outputs are registered or decoded purely from the FSM; there are no input-to-output combinational paths.
- out_state is observable during BUSY (partially transformed) but is valid only while out_valid=1.
- A simultaneous rst and handshake resolves to reset.

## Test plan

- Reset defaults: assert rst for 2 cycles, then check in_ready=1, out_valid=0, busy=0, out_state=0.
- Known bytes: in_state=128'h637c16ed_00000000_63636363_edededed. Require out_state=128'h0001ff53_52525252_00000000_53535353 with out_valid rising exactly 4 cycles after the accept edge.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_state and out_valid stay stable and in_ready stays 0 while in_valid is high. Release out_ready; IDLE follows on the next edge.
- Back-to-back: keep in_valid high with two different states and out_ready=1. Two results arrive in order with a 6-cycle spacing between accept edges. in_state changes during BUSY are ignored.
- Mid-operation reset: pulse rst at edge E2 of a transform. Next cycle shows IDLE defaults. A new block accepted afterwards yields the correct result with no residue.
- Round-trip: for 1000 random states, pass each through the encryption-side S-box model, then this block. Output equals the original state.

Source files
------------

// File: rtl/inv_sub_bytes_seq_if.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq_if
// Handshake bundle for the iterative inverse-SubBytes engine.
//   in_valid  : upstream presents in_state
//   in_ready  : engine can accept a new state
//   in_state  : 128-bit state, column 0 = [127:96], column 3 = [31:0]
//   out_valid : out_state holds a finished result
//   out_ready : downstream accepts out_state
//   out_state : inverse-substituted state
//   busy      : engine is transforming or holding a result
// slave modport is the engine side, master modport is the surrounding datapath.
// ---------------------------------------------------------------------------
interface inv_sub_bytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state, busy
   );

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq
// Iterative AES inverse SubBytes: one 32-bit column per clock through a
// single four-byte inverse S-box slice, columns in order 0,1,2,3.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : inv_sub_bytes_seq_if.slave (valid/ready in and out, busy)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid; loads in_state on accept
// BUSY  | substituting column cnt each edge; cnt=3 write moves to DONE
// DONE  | out_valid=1, result held until out_ready
// ---------------------------------------------------------------------------
module inv_sub_bytes_seq (
   input  logic                 clk,
   input  logic                 rst,
   inv_sub_bytes_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   fsm_t         r_fsm;
   fsm_t         w_fsm_nxt;
   logic [1:0]   r_cnt;
   logic [127:0] r_data;
   logic [31:0]  w_col;
   logic [31:0]  w_col_sub;
   logic         w_in_ready;
   logic         w_out_valid;
   logic         w_busy;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine map (constant folded in), then invert.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   always_comb begin
      w_col = r_data[127:96];
      case (r_cnt)
         2'd0: w_col = r_data[127:96];
         2'd1: w_col = r_data[95:64];
         2'd2: w_col = r_data[63:32];
         2'd3: w_col = r_data[31:0];
         default: w_col = r_data[127:96];
      endcase
   end

   assign w_col_sub = {inv_sbox(w_col[31:24]), inv_sbox(w_col[23:16]),
                       inv_sbox(w_col[15:8]),  inv_sbox(w_col[7:0])};

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_fsm_nxt = S_BUSY;
         end
         S_BUSY: begin
            w_busy = 1'b1;
            if (r_cnt == 2'd3) w_fsm_nxt = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
            if (bus.out_ready) w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm  <= S_IDLE;
         r_cnt  <= 2'd0;
         r_data <= 128'h0;
      end else begin
         r_fsm <= w_fsm_nxt;
         if (r_fsm == S_IDLE && bus.in_valid) begin
            r_data <= bus.in_state;
            r_cnt  <= 2'd0;
         end else if (r_fsm == S_BUSY) begin
            case (r_cnt)
               2'd0: r_data[127:96] <= w_col_sub;
               2'd1: r_data[95:64]  <= w_col_sub;
               2'd2: r_data[63:32]  <= w_col_sub;
               2'd3: r_data[31:0]   <= w_col_sub;
               default: r_data[127:96] <= w_col_sub;
            endcase
            // Wraps to 0 on the final column write.
            r_cnt <= r_cnt + 2'd1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.out_state = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   inv_sub_bytes_seq_if bus ();

   inv_sub_bytes_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference tables built by brute force from the field definition.
   logic [7:0] sbox [256];
   logic [7:0] isbox [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p, x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
         if (x > 255) x = (x ^ 'h11b);
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] inv_state(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = isbox[v[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] fwd_state(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox[v[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Behavioural model: cycles remaining until the result is presented
   // (-1 = idle, 4..1 = transforming, 0 = result presented).
   int           m_rem = -1;
   logic [127:0] m_reg = '0;
   bit           m_known = 0;

   always @(negedge clk) begin
      if (m_known) begin
         chk("in_ready",  {127'b0, bus.in_ready},  {127'b0, (m_rem < 0)});
         chk("out_valid", {127'b0, bus.out_valid}, {127'b0, (m_rem == 0)});
         chk("busy",      {127'b0, bus.busy},      {127'b0, (m_rem >= 0)});
         if (m_rem <= 0) chk("out_state", bus.out_state, m_reg);
      end
      if (rst) begin
         m_rem = -1;
         m_reg = '0;
         m_known = 1;
      end else if (m_known) begin
         if (m_rem < 0) begin
            if (bus.in_valid) begin
               m_rem = 4;
               m_reg = inv_state(bus.in_state);
            end
         end else if (m_rem > 0) begin
            m_rem--;
         end else if (bus.out_ready) begin
            m_rem = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(output int c);
      logic got;
      int   n;
      got = 1'b0;
      for (n = 0; n < 50; n++) begin
         got = bus.in_ready && bus.in_valid;
         tick();
         if (got) break;
      end
      chk("accept_timeout", {127'b0, got}, 128'd1);
      c = cyc;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("valid_timeout", {127'b0, bus.out_valid}, 128'd1);
   endtask

   task automatic wait_handshake();
      logic hs;
      int   n;
      hs = 1'b0;
      for (n = 0; n < 50; n++) begin
         hs = bus.out_valid && bus.out_ready;
         tick();
         if (hs) break;
      end
      chk("handshake_timeout", {127'b0, hs}, 128'd1);
   endtask

   localparam logic [127:0] KNOWN_IN  = 128'h637c16ed_00000000_63636363_edededed;
   localparam logic [127:0] KNOWN_OUT = 128'h0001ff53_52525252_00000000_53535353;

   initial begin
      int           c0, c1, lat;
      logic [127:0] a, b, orig, res;

      build_tables();
      bus.in_valid  = 1'b0;
      bus.in_state  = '0;
      bus.out_ready = 1'b0;

      // Pin the model with literal FIPS-197 values.
      chk("sbox_00",  {120'b0, sbox[8'h00]},  128'h63);
      chk("sbox_53",  {120'b0, sbox[8'h53]},  128'hed);
      chk("isbox_7c", {120'b0, isbox[8'h7c]}, 128'h01);
      chk("isbox_16", {120'b0, isbox[8'h16]}, 128'hff);
      chk("isbox_00", {120'b0, isbox[8'h00]}, 128'h52);
      chk("model_known", inv_state(KNOWN_IN), KNOWN_OUT);

      // Reset defaults.
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready",  {127'b0, bus.in_ready},  128'd1);
      chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      chk("rst_busy",      {127'b0, bus.busy},      128'd0);
      chk("rst_out_state", bus.out_state,           128'h0);

      // Known vector and latency.
      bus.out_ready = 1'b1;
      bus.in_state  = KNOWN_IN;
      bus.in_valid  = 1'b1;
      wait_accept(c0);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      chk("known_latency", 128'(lat), 128'd4);
      chk("known_result", bus.out_state, KNOWN_OUT);
      wait_handshake();

      // Backpressure with in_valid held high.
      bus.out_ready = 1'b0;
      bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
      a = bus.in_state;
      bus.in_valid  = 1'b1;
      wait_accept(c0);
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", {127'b0, bus.out_valid}, 128'd1);
         chk("bp_ready", {127'b0, bus.in_ready},  128'd0);
         chk("bp_data",  bus.out_state, inv_state(a));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_idle", {127'b0, bus.in_ready}, 128'd1);

      // Back-to-back with in_valid high and out_ready high.
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      bus.in_state = a;
      bus.in_valid = 1'b1;
      wait_accept(c0);
      bus.in_state = b;
      wait_valid(lat);
      chk("b2b_first", bus.out_state, inv_state(a));
      wait_accept(c1);
      chk("b2b_spacing", 128'(c1 - c0), 128'd6);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_state = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      wait_valid(lat);
      chk("b2b_second", bus.out_state, inv_state(b));
      wait_handshake();

      // Mid-operation reset at E2.
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid = 1'b1;
      wait_accept(c0);
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_in_ready",  {127'b0, bus.in_ready},  128'd1);
      chk("mrst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      chk("mrst_busy",      {127'b0, bus.busy},      128'd0);
      chk("mrst_out_state", bus.out_state,           128'h0);
      bus.in_state = KNOWN_IN;
      bus.in_valid = 1'b1;
      wait_accept(c0);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      chk("mrst_latency", 128'(lat), 128'd4);
      chk("mrst_result", bus.out_state, KNOWN_OUT);
      wait_handshake();

      // Round trip through the forward S-box model.
      for (int k = 0; k < 1000; k++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 1) == 1);
         bus.in_state  = fwd_state(orig);
         bus.in_valid  = 1'b1;
         wait_accept(c0);
         bus.in_valid = 1'b0;
         wait_valid(lat);
         res = bus.out_state;
         chk("roundtrip", res, orig);
         if (!bus.out_ready) begin
            repeat ($urandom_range(0, 3)) tick();
            bus.out_ready = 1'b1;
         end
         wait_handshake();
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
